// File: rtl/pipe_cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_cla_pkg
// Description : Shared pipeline record type and saturation constants for
//               pipe_cla_adder.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_cla_pkg;

    // Upper bound on WIDTH; records are sized to it so one type serves all builds.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             carry;
        logic [MAX_W-1:0] psum;
        logic [MAX_W-1:0] opa;
        logic [MAX_W-1:0] opb;
    } stage_rec_t;

    function automatic logic [MAX_W-1:0] sat_pos(input int w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_W-1:0] sat_neg(input int w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_cla_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_cla_adder_if
// Description : Operand/result handshake bundle for pipe_cla_adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_cla_adder_if #(
    parameter int WIDTH = 16
) ();

    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             cIn;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             cOut;
    logic             ofl;
    logic             zero;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output inA, inB, cIn, sub, in_valid, out_ready,
        input  in_ready, sum, cOut, ofl, zero, out_valid
    );

    modport slave (
        input  inA, inB, cIn, sub, in_valid, out_ready,
        output in_ready, sum, cOut, ofl, zero, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/pipe_cla_adder_chunk.sv
`default_nettype none
// ============================================================================
// Module      : cla_chunk
// Description : Combinational W-bit generate/propagate lookahead adder with
//               carry-out and carry-into-MSB outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_c;
    logic         w_acc_g;
    logic         w_acc_p;

    // Each carry is the flattened group generate/propagate back to c_i.
    always_comb begin
        w_g     = a_i & b_i;
        w_p     = a_i ^ b_i;
        w_c     = '0;
        w_c[0]  = c_i;
        w_acc_g = 1'b0;
        w_acc_p = 1'b0;
        for (int i = 0; i < W; i++) begin
            w_acc_g = w_g[i];
            w_acc_p = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc_g = w_acc_g | (w_acc_p & w_g[j]);
                w_acc_p = w_acc_p & w_p[j];
            end
            w_c[i+1] = w_acc_g | (w_acc_p & c_i);
        end
    end

    assign s_o    = w_p ^ w_c[W-1:0];
    assign cout_o = w_c[W];
    assign cmsb_o = w_c[W-1];

endmodule
`default_nettype wire

// File: rtl/pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_cla_adder
// Description : NSTG-stage pipelined lookahead adder/subtractor with valid/
//               ready flow control. Define PIPE_CLA_SAT_EN for signed
//               saturation of overflowing results.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_cla_adder
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst,
    pipe_cla_adder_if.slave bus
);

    localparam int NSTG = WIDTH / CHUNK;

    if ((WIDTH % CHUNK) != 0 || NSTG < 2 || WIDTH > MAX_W) begin : g_cfg_check
        $error("pipe_cla_adder: unsupported WIDTH/CHUNK combination");
    end

    logic             advance;
    stage_rec_t       w_in_rec;
    stage_rec_t       w_src   [NSTG];
    stage_rec_t       stage_d [NSTG-1];
    stage_rec_t       stage_q [NSTG-1];
    logic [CHUNK-1:0] w_s     [NSTG];
    logic [NSTG-1:0]  w_co;
    logic [NSTG-1:0]  w_cm;
    logic [WIDTH-1:0] w_fsum;
    logic [WIDTH-1:0] sum_d;
    logic             ofl_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ofl_q;
    logic             zero_q;
    logic             out_valid_q;
    logic             w_unused;

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    // Subtraction enters as A + ~B with a forced carry-in of 1.
    always_comb begin
        w_in_rec       = '0;
        w_in_rec.valid = bus.in_valid;
        w_in_rec.sub   = bus.sub;
        w_in_rec.carry = bus.sub | bus.cIn;
        w_in_rec.opa   = MAX_W'(bus.inA);
        w_in_rec.opb   = MAX_W'(bus.sub ? ~bus.inB : bus.inB);
    end

    assign w_src[0] = w_in_rec;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign w_src[k] = stage_q[k-1];
        end

        cla_chunk #(
            .W (CHUNK)
        ) u_chunk (
            .a_i    (w_src[k].opa[k*CHUNK +: CHUNK]),
            .b_i    (w_src[k].opb[k*CHUNK +: CHUNK]),
            .c_i    (w_src[k].carry),
            .s_o    (w_s[k]),
            .cout_o (w_co[k]),
            .cmsb_o (w_cm[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NSTG - 1; k++) begin
            stage_d[k]                         = w_src[k];
            stage_d[k].psum[k*CHUNK +: CHUNK]  = w_s[k];
            stage_d[k].carry                   = w_co[k];
        end
    end

    always_comb begin
        w_fsum                                = WIDTH'(w_src[NSTG-1].psum);
        w_fsum[(NSTG-1)*CHUNK +: CHUNK]       = w_s[NSTG-1];
        ofl_d                                 = w_co[NSTG-1] ^ w_cm[NSTG-1];
`ifdef PIPE_CLA_SAT_EN
        // A wrapped negative sign on overflow means the true result was positive.
        if (ofl_d) begin
            sum_d = w_fsum[WIDTH-1] ? WIDTH'(sat_pos(WIDTH)) : WIDTH'(sat_neg(WIDTH));
        end else begin
            sum_d = w_fsum;
        end
`else
        sum_d = w_fsum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG - 1; k++) begin
                stage_q[k] <= '0;
            end
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ofl_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NSTG - 1; k++) begin
                stage_q[k] <= stage_d[k];
            end
            sum_q       <= sum_d;
            cout_q      <= w_co[NSTG-1];
            ofl_q       <= ofl_d;
            zero_q      <= w_src[NSTG-1].valid && (sum_d == '0);
            out_valid_q <= w_src[NSTG-1].valid;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cOut      = cout_q;
    assign bus.ofl       = ofl_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;

    // Fully consumed operand chunks and intermediate MSB carries have no reader.
    assign w_unused = ^{w_src[NSTG-1], w_cm};

endmodule
`default_nettype wire

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width.
REQ-002 SHALL have parameter CHUNK, default 4, bits resolved per pipeline stage; WIDTH SHALL be a multiple of CHUNK; NSTG = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port inA, input, WIDTH, operand A.
REQ-006 SHALL have port inB, input, WIDTH, operand B.
REQ-007 SHALL have port cIn, input, 1, carry-in; ignored when sub=1.
REQ-008 SHALL have port sub, input, 1, 1 selects A-B, computed as A + ~B + 1.
REQ-009 SHALL have port in_valid, input, 1, operands valid.
REQ-010 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-011 SHALL have port sum, output, WIDTH, result.
REQ-012 SHALL have port cOut, output, 1, carry out of bit WIDTH-1.
REQ-013 SHALL have port ofl, output, 1, two's-complement signed overflow.
REQ-014 SHALL have port zero, output, 1, sum == 0.
REQ-015 SHALL have port out_valid, output, 1, result valid.
REQ-016 SHALL have port out_ready, input, 1, consumer accepts result.

Function
REQ-017 SHALL be an NSTG-stage pipeline; stage k resolves bits [k*CHUNK +: CHUNK] with a CHUNK-bit lookahead adder using the carry registered by stage k-1 (stage 0 uses cIn or 1 for sub).
REQ-018 SHALL skew operand chunks not yet consumed forward with their transaction and hold completed sum chunks so all bits of one transaction emerge together.
REQ-019 SHALL have latency exactly NSTG cycles from accepted input to out_valid with no stall; throughput one transaction per cycle.
REQ-020 SHALL use advance = !out_valid || out_ready; in_ready = advance; all stages shift only when advance=1.
REQ-021 SHALL accept a transaction only when in_valid && in_ready; when advance=1 and in_valid=0 a bubble enters stage 0.
REQ-022 SHALL hold sum, cOut, ofl, zero and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL compute ofl = carry into MSB XOR carry out of MSB of the final stage.
REQ-024 SHALL have in_ready depend combinationally on out_ready (no skid buffer).
REQ-025 SHALL, on simultaneous output drain and input accept, perform both in the same cycle without bubble.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, clear all stage valid bits, sum=0, cOut=0, ofl=0, zero=0, out_valid=0; in-flight transactions are discarded.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset is released.
REQ-028 SHALL give rst priority over any handshake in the same cycle.

Configuration
REQ-029 SHALL, with macro PIPE_CLA_SAT_EN defined, replace sum on ofl=1 with the signed saturation value (0x7FFF for positive overflow, 0x8000 for negative at WIDTH=16), ofl still reported, zero computed on the saturated value.
REQ-030 SHALL, without PIPE_CLA_SAT_EN, output the wrapped sum; no saturation logic is present.

Structure
REQ-031 SHALL place the per-stage pipeline record type (valid, carry, partial sum, remaining operands, sub flag) and the saturation constants in shared package pipe_cla_pkg.
REQ-032 SHALL instantiate NSTG copies of one combinational sub-module cla_chunk (CHUNK-bit generate/propagate lookahead adder with carry-out and MSB carry-in outputs).

Verification
REQ-033 SHALL cover: WIDTH=16, A=0x00FF, B=0x0001, cIn=0, sub=0 -> 4 cycles later sum=0x0100, cOut=0, ofl=0, zero=0.
REQ-034 SHALL cover: A=0x7FFF, B=0x0001, add -> ofl=1; sum=0x8000 without macro, 0x7FFF with PIPE_CLA_SAT_EN.
REQ-035 SHALL cover: A=0x1234, B=0x1234, sub=1 -> sum=0x0000, cOut=1, zero=1, ofl=0.
REQ-036 SHALL cover: 8 back-to-back inputs with out_ready held 0 from cycle 5 for 3 cycles -> in_ready=0 during stall, outputs held, all 8 results delivered in order, none lost or duplicated.
REQ-037 SHALL cover: rst asserted with 3 transactions in flight -> next cycle out_valid=0, no stale result ever appears, in_ready=1.
REQ-038 SHALL cover: random A/B/cIn/sub with random in_valid/out_ready against a reference model for WIDTH=32, CHUNK=8 -> all results match.
